// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus shared APB bus bundle for apb_master_bridge.
// The master modport is the bridge side. The slave modport is the requester and APB slaves side.
interface apb_master_bridge_if #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADD_WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0]     cmd_wdata;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_rdata;
    logic                 rsp_err;
    logic                 Psel1;
    logic                 Psel2;
    logic                 Penable;
    logic                 Pwrite;
    logic [ADD_WIDTH-2:0] Paddr;
    logic [WIDTH-1:0]     Pwdata;
    logic [WIDTH-1:0]     Prdata1;
    logic [WIDTH-1:0]     Prdata2;
    logic                 Pready1;
    logic                 Pready2;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  Prdata1, Prdata2, Pready1, Pready2,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output Prdata1, Prdata2, Pready1, Pready2,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB3 bridge driving two slaves on a shared bus.
// Has an optional one-cycle delayed read-data capture and a Pready timeout.
module apb_master_bridge #(
    parameter int ADD_WIDTH     = 9,
    parameter int WIDTH         = 32,
    parameter int RD_SAMPLE_DLY = 1,
    parameter int TIMEOUT       = 16
) (
    input  logic                Pclk,
    input  logic                Presetn,
    apb_master_bridge_if.master bus
);
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDCAP} state_t;

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 psel1_q, psel1_d;
    logic                 psel2_q, psel2_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADD_WIDTH-2:0] paddr_q, paddr_d;
    logic [WIDTH-1:0]     pwdata_q, pwdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]        wait_q, wait_d;
    logic                 ready;
    logic [WIDTH-1:0]     rdata_mux;

    // sel_q = 1 routes slave 2; the other slave's Pready/Prdata are ignored
    assign ready     = sel_q ? bus.Pready2 : bus.Pready1;
    assign rdata_mux = sel_q ? bus.Prdata2 : bus.Prdata1;

    assign bus.cmd_ready = Presetn && (state_q == IDLE);
    assign bus.Psel1     = psel1_q;
    assign bus.Psel2     = psel2_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wait_d      = wait_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    sel_d    = bus.cmd_addr[ADD_WIDTH-1];
                    psel1_d  = !bus.cmd_addr[ADD_WIDTH-1];
                    psel2_d  = bus.cmd_addr[ADD_WIDTH-1];
                    paddr_d  = bus.cmd_addr[ADD_WIDTH-2:0];
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = IDLE;
                    end else if (RD_SAMPLE_DLY == 0) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rdata_mux;
                        state_d     = IDLE;
                    end else begin
                        state_d = RDCAP;
                    end
                end else if ((TIMEOUT > 0) && (wait_q == CW'(TMO_LIM))) begin
                    // Limit reached with ready still low: abort as an error response
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else if (TIMEOUT > 0) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            RDCAP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_mux;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
